// File: rtl/opo_package.sv
// Shared word sizes, sample types and the sine-table generator used by the
// modulator and the lock-in reference path.
package opo_package;

    localparam int word_width       = 16;
    localparam int config_reg_width = 16;
    localparam int lut_depth        = 1024;
    localparam int quarter_offset   = 256;

    typedef logic signed [word_width-1:0]   sample_t;
    typedef logic signed [2*word_width-1:0] prod_t;
    typedef logic signed [2*word_width:0]   sum_t;

    localparam sample_t sample_max = sample_t'((2**(word_width-1)) - 1);
    localparam sample_t sample_min = sample_t'(-(2**(word_width-1)));

    // round(FS*sin(2*pi*k/depth)), rounding half away from zero
    function automatic sample_t sine_entry(input int k);
        real fs;
        real v;
        fs = real'((2**(word_width-1)) - 1);
        v  = fs * $sin(6.283185307179586 * real'(k) / real'(lut_depth));
        if (v >= 0.0)
            return sample_t'($rtoi(v + 0.5));
        else
            return sample_t'(-$rtoi(0.5 - v));
    endfunction

endpackage

// File: rtl/sine_lut_1024.sv
// Dual-port sine ROM with one-cycle registered reads; shared by the
// modulator and the lock-in reference generator.
module sine_lut_1024
    import opo_package::*;
#(
    parameter int LUT_LOG2 = 10
) (
    input  logic                clk,
    input  logic [LUT_LOG2-1:0] i_addr_a,
    input  logic [LUT_LOG2-1:0] i_addr_b,
    output sample_t             o_data_a,
    output sample_t             o_data_b
);

    localparam int DEPTH = 1 << LUT_LOG2;

    sample_t w_rom [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
            assign w_rom[gi] = sine_entry(gi);
        end
    endgenerate

    // No reset on the read registers so the array maps onto block ROM
    always_ff @(posedge clk) begin
        o_data_a <= w_rom[i_addr_a];
        o_data_b <= w_rom[i_addr_b];
    end

endmodule

// File: rtl/iq_dither_modulator.sv
// I*sin + Q*cos dither synthesiser with aligned references and wrap sync.
// Define IQ_MOD_SATURATE_EN to clamp the output instead of wrapping it.
module iq_dither_modulator
    import opo_package::*;
#(
    parameter int LUT_LOG2    = 10,
    parameter int PIPE_STAGES = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [config_reg_width-1:0] period,
    input  sample_t                     amp_i,
    input  sample_t                     amp_q,
    input  logic                        amp_valid,
    output logic                        amp_ready,
    output sample_t                     dac_out,
    output sample_t                     sin_ref,
    output sample_t                     cos_ref,
    output logic [LUT_LOG2-1:0]         phase_idx,
    output logic                        sync
);

    typedef struct packed {
        logic [LUT_LOG2-1:0] idx;
        logic                wrap;
    } meta_t;

    logic [config_reg_width-1:0] r_div;
    logic [LUT_LOG2-1:0]         r_idx;
    logic                        r_wrapped;
    logic                        r_ready;
    sample_t                     r_pend_i, r_pend_q;
    sample_t                     r_act_i, r_act_q;
    sample_t                     r_ai1, r_aq1;
    prod_t                       r_prod_i, r_prod_q;
    sample_t                     r_sin2, r_cos2;
    meta_t                       r_meta [PIPE_STAGES];

    logic                        w_run;
    logic                        w_step;
    logic                        w_wrap;
    logic [LUT_LOG2-1:0]         w_cos_idx;
    sample_t                     w_sin, w_cos;
    sample_t                     w_dac;

    // >= rather than == so a period shrunk below the running count steps at once
    assign w_run     = enable && (period != '0);
    assign w_step    = w_run && (r_div >= (period - config_reg_width'(1)));
    assign w_wrap    = w_step && (r_idx == '1);
    assign w_cos_idx = r_idx + LUT_LOG2'(quarter_offset);
    assign amp_ready = r_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div     <= '0;
            r_idx     <= '0;
            r_wrapped <= 1'b0;
            r_ready   <= 1'b1;
            r_pend_i  <= '0;
            r_pend_q  <= '0;
            r_act_i   <= '0;
            r_act_q   <= '0;
        end else begin
            if (w_run) begin
                if (w_step) begin
                    r_div <= '0;
                    r_idx <= r_idx + LUT_LOG2'(1);
                end else begin
                    r_div <= r_div + config_reg_width'(1);
                end
            end
            r_wrapped <= w_wrap;
            if (w_wrap) begin
                r_act_i <= r_pend_i;
                r_act_q <= r_pend_q;
            end
            // A capture on the wrap cycle keeps ready low until the next wrap
            if (amp_valid && r_ready) begin
                r_pend_i <= amp_i;
                r_pend_q <= amp_q;
                r_ready  <= 1'b0;
            end else if (w_wrap) begin
                r_ready <= 1'b1;
            end
        end
    end

    sine_lut_1024 #(
        .LUT_LOG2 (LUT_LOG2)
    ) u_lut (
        .clk      (clk),
        .i_addr_a (r_idx),
        .i_addr_b (w_cos_idx),
        .o_data_a (w_sin),
        .o_data_b (w_cos)
    );

    always_comb begin
`ifdef IQ_MOD_SATURATE_EN
        sum_t w_shift;
        w_shift = (sum_t'(r_prod_i) + sum_t'(r_prod_q)) >>> (word_width - 1);
        if (w_shift > sum_t'(sample_max))
            w_dac = sample_max;
        else if (w_shift < sum_t'(sample_min))
            w_dac = sample_min;
        else
            w_dac = sample_t'(w_shift);
`else
        w_dac = sample_t'((sum_t'(r_prod_i) + sum_t'(r_prod_q)) >>> (word_width - 1));
`endif
    end

    // Amplitudes ride with their table sample so a wrap never splits a sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ai1    <= '0;
            r_aq1    <= '0;
            r_prod_i <= '0;
            r_prod_q <= '0;
            r_sin2   <= '0;
            r_cos2   <= '0;
            dac_out  <= '0;
            sin_ref  <= '0;
            cos_ref  <= '0;
            for (int i = 0; i < PIPE_STAGES; i++)
                r_meta[i] <= '0;
        end else begin
            r_ai1    <= r_act_i;
            r_aq1    <= r_act_q;
            r_prod_i <= prod_t'(r_ai1) * prod_t'(w_sin);
            r_prod_q <= prod_t'(r_aq1) * prod_t'(w_cos);
            r_sin2   <= w_sin;
            r_cos2   <= w_cos;
            dac_out  <= w_dac;
            sin_ref  <= r_sin2;
            cos_ref  <= r_cos2;
            r_meta[0] <= '{idx: r_idx, wrap: r_wrapped};
            for (int i = 1; i < PIPE_STAGES; i++)
                r_meta[i] <= r_meta[i-1];
        end
    end

    assign phase_idx = r_meta[PIPE_STAGES-1].idx;
    assign sync      = r_meta[PIPE_STAGES-1].wrap;

endmodule

// File: tb/tb_iq_dither_modulator.sv
// Self-checking bench: constant vector table, directed corner sequences and
// randomised traffic against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_iq_dither_modulator;
    import opo_package::*;

    localparam int FS  = 32767;
    localparam int LIM = 10000;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] period;
    sample_t     amp_i, amp_q;
    logic        amp_valid;
    logic        amp_ready;
    sample_t     dac_out, sin_ref, cos_ref;
    logic [9:0]  phase_idx;
    logic        sync;

    always #5 clk = ~clk;

    iq_dither_modulator dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .period    (period),
        .amp_i     (amp_i),
        .amp_q     (amp_q),
        .amp_valid (amp_valid),
        .amp_ready (amp_ready),
        .dac_out   (dac_out),
        .sin_ref   (sin_ref),
        .cos_ref   (cos_ref),
        .phase_idx (phase_idx),
        .sync      (sync)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural reference ----------------
    typedef struct {
        int idx;
        int ai;
        int aq;
        bit wrap;
    } snap_t;

    int    m_div, m_idx, m_ai, m_aq, m_pi, m_pq;
    bit    m_ready;
    snap_t hist [4];
    int    mask;

    function automatic int lut(input int k);
        real r;
        r = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(k % 1024) / 1024.0);
        return $rtoi($floor(r + 0.5));
    endfunction

    function automatic int model_dac(input int ai, input int aq, input int k);
        longint s;
        s = longint'(ai) * longint'(lut(k)) + longint'(aq) * longint'(lut(k + 256));
        s = s >>> 15;
`ifdef IQ_MOD_SATURATE_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`else
        s = s & 64'hFFFF;
        if (s >= 32768) s = s - 65536;
`endif
        return int'(s);
    endfunction

    task automatic model_reset();
        m_div = 0; m_idx = 0; m_ai = 0; m_aq = 0; m_pi = 0; m_pq = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) hist[i] = '{0, 0, 0, 1'b0};
        mask = 1;
    endtask

    task automatic model_step();
        bit run, step, wrap, cap;
        run  = enable && (period != 0);
        step = run && (m_div >= int'(period) - 1);
        wrap = step && (m_idx == 1023);
        cap  = amp_valid && m_ready;
        if (run) begin
            if (step) begin
                m_div = 0;
                m_idx = (m_idx + 1) % 1024;
            end else begin
                m_div++;
            end
        end
        if (wrap) begin
            m_ai = m_pi;
            m_aq = m_pq;
        end
        if (cap) begin
            m_pi = int'(amp_i);
            m_pq = int'(amp_q);
            m_ready = 1'b0;
        end else if (wrap) begin
            m_ready = 1'b1;
        end
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = '{m_idx, m_ai, m_aq, wrap};
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_chk(input string nm, input int n);
        checks++;
        if (n >= LIM) begin
            errors++;
            $display("FAIL %s: waited %0d cycles, limit %0d", nm, n, LIM);
        end
    endtask

    task automatic compare_all();
        snap_t h;
        h = hist[3];
        chk("amp_ready", longint'(amp_ready), longint'(m_ready));
        if (mask > 0) begin
            mask--;
        end else begin
            chk("dac_out", longint'(dac_out), longint'(model_dac(h.ai, h.aq, h.idx)));
            chk("sin_ref", longint'(sin_ref), longint'(lut(h.idx)));
            chk("cos_ref", longint'(cos_ref), longint'(lut(h.idx + 256)));
            chk("phase_idx", longint'(phase_idx), longint'(h.idx));
            chk("sync", longint'(sync), longint'(h.wrap));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!amp_ready && n < LIM) begin tick(); n++; end
        timeout_chk(nm, n);
    endtask

    task automatic wait_phase(input string nm, input int target);
        int n = 0;
        while (int'(phase_idx) != target && n < LIM) begin tick(); n++; end
        timeout_chk(nm, n);
    endtask

    task automatic push(input int ai, input int aq);
        wait_ready("push_ready");
        amp_i = sample_t'(ai);
        amp_q = sample_t'(aq);
        amp_valid = 1'b1;
        tick();
        amp_valid = 1'b0;
    endtask

    task automatic do_reset_now();
        #2 rst = 1'b0;
        #1;
        chk("rst_dac", longint'(dac_out), 0);
        chk("rst_sin", longint'(sin_ref), 0);
        chk("rst_cos", longint'(cos_ref), 0);
        chk("rst_phase", longint'(phase_idx), 0);
        chk("rst_sync", longint'(sync), 0);
        chk("rst_ready", longint'(amp_ready), 1);
        model_reset();
        amp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // ---------------- constant vector table ----------------
    typedef struct {
        int ai;
        int aq;
        int idx;
        int e_sin;
        int e_cos;
        int e_dac;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int nsync;

        vecs[0]  = '{FS,     0,   0,      0,  32767,      0};
        vecs[1]  = '{FS,     0, 256,  32767,      0,  32766};
        vecs[2]  = '{FS,     0, 768, -32767,      0, -32767};
        vecs[3]  = '{FS,     0, 128,  23170,  23170,  23169};
        vecs[4]  = '{0,     FS,   0,      0,  32767,  32766};
        vecs[5]  = '{0,     FS, 512,      0, -32767, -32767};
        vecs[6]  = '{0,    -FS,   0,      0,  32767, -32767};
`ifdef IQ_MOD_SATURATE_EN
        vecs[7]  = '{FS,    FS, 128,  23170,  23170,  32767};
`else
        vecs[7]  = '{FS,    FS, 128,  23170,  23170, -19198};
`endif
        vecs[8]  = '{1000,   0, 256,  32767,      0,    999};
        vecs[9]  = '{-16384, 0, 256,  32767,      0, -16384};
        vecs[10] = '{1000, -1000, 128, 23170, 23170,      0};

        rst = 1'b0; enable = 1'b1; period = 16'd1;
        amp_i = '0; amp_q = '0; amp_valid = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("init_dac", longint'(dac_out), 0);
        chk("init_sin", longint'(sin_ref), 0);
        chk("init_cos", longint'(cos_ref), 0);
        chk("init_phase", longint'(phase_idx), 0);
        chk("init_sync", longint'(sync), 0);
        chk("init_ready", longint'(amp_ready), 1);
        rst = 1'b1;
        $display("seq reset_state checked");

        for (int v = 0; v < 11; v++) begin
            push(vecs[v].ai, vecs[v].aq);
            wait_ready("vec_apply");
            wait_phase("vec_phase", vecs[v].idx);
            chk("vec_sin", longint'(sin_ref), longint'(vecs[v].e_sin));
            chk("vec_cos", longint'(cos_ref), longint'(vecs[v].e_cos));
            chk("vec_dac", longint'(dac_out), longint'(vecs[v].e_dac));
            $display("vec %0d I=%0d Q=%0d idx=%0d dac=%0d sin=%0d cos=%0d",
                     v, vecs[v].ai, vecs[v].aq, vecs[v].idx, dac_out, sin_ref, cos_ref);
        end

        // sync spacing at period 4 is one revolution of 4096 clocks
        period = 16'd4;
        n = 0;
        while (!sync && n < LIM) begin tick(); n++; end
        timeout_chk("sync_first", n);
        n = 0;
        do begin tick(); n++; end while (!sync && n < LIM);
        chk("sync_period", n, 4096);
        $display("seq sync_period measured %0d", n);

        // handshake: accept at idx 500, hold a second request while not ready
        n = 0;
        while (m_idx != 500 && n < LIM) begin tick(); n++; end
        timeout_chk("hs_idx500", n);
        push(1000, 0);
        amp_i = sample_t'(2222);
        amp_q = '0;
        amp_valid = 1'b1;
        n = 0;
        while (!amp_ready && n < LIM) begin tick(); n++; end
        amp_valid = 1'b0;
        timeout_chk("hs_wrap", n);
        wait_phase("hs_phase", 256);
        chk("hs_dac_new_amp", longint'(dac_out), 999);
        chk("hs_held_not_captured", longint'(amp_ready), 1);
        $display("seq handshake ready_low_cycles=%0d dac=%0d", n, dac_out);

        // request landing on the wrap-event cycle waits a full revolution
        period = 16'd1;
        n = 0;
        while (m_idx != 1023 && n < LIM) begin tick(); n++; end
        timeout_chk("wc_idx1023", n);
        push(3000, 0);
        chk("wc_ready_after_wrap", longint'(amp_ready), 0);
        wait_phase("wc_phase_old", 256);
        chk("wc_dac_old", longint'(dac_out), 999);
        wait_ready("wc_apply");
        wait_phase("wc_phase_new", 256);
        chk("wc_dac_new", longint'(dac_out), 2999);
        $display("seq wrap_cycle_push dac=%0d", dac_out);

        // freeze via enable and via period 0
        nsync = 0;
        enable = 1'b0;
        repeat (50) begin tick(); if (sync) nsync++; end
        enable = 1'b1;
        period = 16'd0;
        repeat (50) begin tick(); if (sync) nsync++; end
        chk("freeze_no_sync", nsync, 0);
        period = 16'd3;
        repeat (20) tick();
        $display("seq freeze phase=%0d", phase_idx);

        // shrinking period below the running count forces a step
        period = 16'd8;
        n = 0;
        while (m_div != 6 && n < LIM) begin tick(); n++; end
        timeout_chk("pchg_div6", n);
        period = 16'd2;
        repeat (12) tick();
        $display("seq period_change phase=%0d", phase_idx);

        // randomised traffic with a reset in the middle
        period = 16'd1;
        for (int c = 0; c < 5000; c++) begin
            if (c == 2600) begin
                do_reset_now();
                $display("seq mid_run_reset at cycle %0d", c);
            end
            enable = ($urandom % 10) != 0;
            if ($urandom % 64 == 0) period = 16'($urandom_range(0, 3));
            if (!amp_valid && ($urandom % 40 == 0)) begin
                amp_i = sample_t'(int'($urandom_range(0, 32766)) - 16383);
                amp_q = sample_t'(int'($urandom_range(0, 32766)) - 16383);
                amp_valid = 1'b1;
            end else if (amp_valid && ($urandom % 3 == 0)) begin
                amp_valid = 1'b0;
            end
            tick();
        end
        amp_valid = 1'b0;
        $display("seq random traffic done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iq_dither_modulator.md
# iq_dither_modulator

Transmit-side counterpart of the lock-in amplifier. It synthesises the dither/drive waveform `I*sin + Q*cos` from the same 1024-entry phase table the lock-in uses, stepping one table position every `period` clocks. It drives the DAC and exports phase-aligned sine/cosine references plus a phase-zero sync strobe, so a downstream `lock_in_amplifier` can demodulate exactly what was transmitted. Amplitude updates arrive over a valid/ready handshake and take effect only at a table wrap, so they are glitch-free.

## Interface
Parameters:
- `LUT_LOG2`, 10, log2 of table depth; table depth is 1024.
- `PIPE_STAGES`, 3, latency from table index to `dac_out`. This value is fixed; any other value is illegal.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when low, the phase counters hold.
- `period`  in  `config_reg_width`  clocks per table step; 0 freezes the phase.
- `amp_i`, `amp_q`  in  `word_width` each  signed amplitude request.
- `amp_valid`  in  1  request strobe.
- `amp_ready`  out  1  high when no update is pending.
- `dac_out`  out  `word_width`  signed modulated output.
- `sin_ref`, `cos_ref`  out  `word_width` each  signed references, aligned with `dac_out`.
- `phase_idx`  out  `LUT_LOG2`  table index of the current `dac_out` sample.
- `sync`  out  1  one-cycle pulse when `phase_idx` is 0 and a step has just occurred.

## Operation
- Step counter `div` runs 0..period-1. When `div == period-1` and `enable` is high, `idx` increments and `div` clears.
  - `idx` wraps 1023→0; that wrap cycle is called the *wrap event*.
  - If `period` changes mid-count and `div >= period`, the next cycle forces a step.
- Cosine index = `(idx + 256) mod 1024`. Both indices read the shared table.
- Table entries are `round(FS*sin(2πk/1024))`, where `FS = 2^(word_width-1)-1`.
- Active amplitudes `act_i`/`act_q` reset to 0.
- Amplitude update path:
  - When `amp_valid & amp_ready`, the request is captured into the pending registers and `amp_ready` falls.
  - On a wrap event, pending values move to active and `amp_ready` rises the following cycle.
  - A request accepted in the wrap-event cycle is not applied; it waits for the next wrap.
  - If `amp_valid` is held while `amp_ready` is low, the request is not captured.
- Arithmetic:
  - Products `act_i*sin` and `act_q*cos` are signed, 2·`word_width` bits each.
  - Their sum is 2·`word_width`+1 bits.
  - The sum is arithmetically shifted right by `word_width-1`, then reduced to `word_width` bits (see Configuration).
- Reset values: `dac_out`, `sin_ref`, `cos_ref`, `phase_idx`, `sync` = 0; `amp_ready` = 1; `div`, `idx`, pending and active registers = 0.
- Reset mid-operation clears all state immediately (asynchronously) and discards any pending update.

## Timing
- Pipeline, 3 cycles:
  - Stage 1: registered table read.
  - Stage 2: registered multiplies.
  - Stage 3: registered sum/shift/saturate into `dac_out`.
- `sin_ref`, `cos_ref` and `phase_idx` are delayed to match, so all outputs update on the same edge.
- `sync` asserts 3 cycles after the wrap event, coincident with the first `dac_out` sample at `phase_idx` 0.
- New amplitudes first appear on `dac_out` 3 cycles after the wrap event.
- With `enable` low or `period` = 0, the outputs keep recomputing from the frozen index, and `sync` does not pulse.
- `enable` rising resumes the count from the held `div`.

## Configuration
- `IQ_MOD_SATURATE_EN` defined: the shifted sum is clamped to [-2^(word_width-1), 2^(word_width-1)-1].
- Not defined: the shifted sum is truncated to the low `word_width` bits (two's-complement wrap). The software must then keep |I|+|Q| ≤ FS.

## Structure
- `opo_package` provides:
  - `word_width` and `config_reg_width`.
  - New constants `lut_depth = 1024` and `quarter_offset = 256`.
  - A `typedef` for the signed sample type.
- Sub-module `sine_lut_1024`: ROM with two synchronous read ports (1-cycle latency), initialised from a generated table.
  - This block and the lock-in's reference generator both instantiate it.

## Test plan
- Basic sine: `period`=4, push I=FS, Q=0 → after the first wrap plus 3 cycles, `dac_out == sin_ref` every cycle; `phase_idx` advances every 4 clocks; `sync` period is 4096 clocks.
- Cosine: I=0, Q=FS → `dac_out == cos_ref`. Loopback into `lock_in_amplifier` with the same `period` reads i≈0, q≈full scale. With Q=-FS, it reads q≈-full scale.
- Saturation: I=Q=FS, with `IQ_MOD_SATURATE_EN` defined → at `phase_idx`=128, `dac_out` = FS (not wrapped negative). Without the macro, the wrapped value matches the model.
- Handshake: push I=1000 at `idx`=500 → `amp_ready` is 0 until 1 cycle after the wrap. `dac_out` keeps the old amplitude until wrap+3. A second push held during this window is not captured. A push exactly on the wrap-event cycle is applied one table revolution later.
- Freeze: `period`=0, or `enable`=0 for 50 cycles → `phase_idx` is constant, there is no `sync`, and the count resumes from the held position.
- Reset mid-run: assert `rst`=0 at an arbitrary cycle → all outputs are 0 and `amp_ready` = 1 immediately. After release, the first step occurs `period` clocks later from `idx` 0.
